// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: read-return owner
// encoding, default bus widths and the streak counter width.
package mem_arb_pkg;

  // Who the memory read data arriving next cycle belongs to
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_LS   = 2'd2
  } owner_e;

  localparam int DEF_DWIDTH = 16;
  localparam int DEF_AWIDTH = 12;

  // The LS streak counter is 4 bits, so the limit must fit in 1..15
  localparam int STREAK_W   = 4;
  localparam int STREAK_MAX = (1 << STREAK_W) - 1;

  // Clamp a requested streak limit into the range the counter can hold
  function automatic logic [STREAK_W-1:0] clamp_streak(input int limit);
    if (limit < 1) begin
      return STREAK_W'(1);
    end else if (limit > STREAK_MAX) begin
      return STREAK_W'(STREAK_MAX);
    end else begin
      return STREAK_W'(limit);
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment;
// once all ones the count holds until cleared.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count events, stick at the maximum, clear synchronously
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous memory port between instruction fetch (IF)
// and load/store (LS). LS has priority, but after MAX_LS_STREAK consecutive
// LS grants with IF waiting, IF is granted once so fetch always progresses.
// Read data returns one cycle after the grant and is steered to the owner.
// Optional stall statistics are enabled with MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DWIDTH        = DEF_DWIDTH,
  parameter int AWIDTH        = DEF_AWIDTH,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction fetch requester
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  // Load/store requester
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [AWIDTH-1:0] ls_addr,
  input  logic [DWIDTH-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DWIDTH-1:0] ls_rdata,
`ifdef MEM_PORT_ARBITER_STATS_EN
  // Stall statistics
  output logic [15:0]       if_stall_cnt,
  output logic [15:0]       ls_stall_cnt,
`endif
  // Memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = clamp_streak(MAX_LS_STREAK);

  owner_e              owner_q;
  owner_e              owner_d;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                streak_full;
  logic                if_win;
  logic                ls_win;

  assign streak_full = (streak_q == STREAK_LIMIT);

  // Pick this cycle's winner: LS first unless IF has waited out the streak
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (!rst) begin
      if (ls_req && !(if_req && streak_full)) begin
        ls_win = 1'b1;
      end else if (if_req) begin
        if_win = 1'b1;
      end
    end
  end

  assign if_gnt = if_win;
  assign ls_gnt = ls_win;

  // Drive the memory port from the winner; idle port is fully quiet
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_win) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_win) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // Work out who owns the read data coming back next cycle
  always_comb begin
    owner_d = OWNER_NONE;
    if (if_win) begin
      owner_d = OWNER_IF;
    end else if (ls_win && !ls_we) begin
      owner_d = OWNER_LS;
    end
  end

  // Read-return owner register; reset drops any read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWNER_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Count LS grants that kept a waiting IF out; any IF grant or idle IF clears
  always_comb begin
    streak_d = streak_q;
    if (ls_win && if_req) begin
      streak_d = streak_q + STREAK_W'(1);
    end else if (if_win || !if_req) begin
      streak_d = '0;
    end
  end

  // Streak register
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  // Steer returning read data; suppress valids while reset is held
  always_comb begin
    if_rvalid = !rst && (owner_q == OWNER_IF);
    ls_rvalid = !rst && (owner_q == OWNER_LS);
    if_rdata  = mem_rdata;
    ls_rdata  = mem_rdata;
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  // Cycles each requester spent waiting with its request up
  sat_counter #(
    .WIDTH(16)
  ) u_if_stall (
    .clk  (clk),
    .clr  (rst),
    .inc  (if_req && !if_gnt),
    .count(if_stall_cnt)
  );

  sat_counter #(
    .WIDTH(16)
  ) u_ls_stall (
    .clk  (clk),
    .clr  (rst),
    .inc  (ls_req && !ls_gnt),
    .count(ls_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory.
// Covers the stall counters when MEM_PORT_ARBITER_STATS_EN is defined.
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0]   if_stall_cnt;
  logic [15:0]   ls_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  mem_port_arbiter #(
    .DWIDTH       (DW),
    .AWIDTH       (AW),
    .MAX_LS_STREAK(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_gnt   (ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata (ls_rdata),
`ifdef MEM_PORT_ARBITER_STATS_EN
    .if_stall_cnt(if_stall_cnt),
    .ls_stall_cnt(ls_stall_cnt),
`endif
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Synchronous memory: writes land on the edge, reads return next cycle
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic applyStimulus(input logic i_req, input logic [AW-1:0] i_addr,
                               input logic l_req, input logic l_we,
                               input logic [AW-1:0] l_addr, input logic [DW-1:0] l_wdata);
    if_req   = i_req;
    if_addr  = i_addr;
    ls_req   = l_req;
    ls_we    = l_we;
    ls_addr  = l_addr;
    ls_wdata = l_wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Move to just after the next rising edge, where inputs change
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  int contIf [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int clrIfReq [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
  int clrExpIf [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    for (int a = 0; a < 4; a++) mem[a] = 16'hA000 + DW'(a);
    mem[5]   = 16'h5555;
    mem[7]   = 16'h7777;
    mem[100] = 16'h0000;
    mem_rdata = '0;

    // Reset with both requests up: nothing may be granted
    rst = 1'b1;
    applyStimulus(1'b1, 12'd1, 1'b1, 1'b1, 12'd2, 16'hFFFF);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_if_gnt", if_gnt, 0);
    checkOutput("rst_ls_gnt", ls_gnt, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_if_rvalid", if_rvalid, 0);
    checkOutput("rst_ls_rvalid", ls_rvalid, 0);
`ifdef MEM_PORT_ARBITER_STATS_EN
    checkOutput("rst_if_stall_cnt", if_stall_cnt, 0);
    checkOutput("rst_ls_stall_cnt", ls_stall_cnt, 0);
`endif
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 16'h0);

    // IF-only stream: grant every cycle, data one cycle later
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(1'b1, AW'(i), 1'b0, 1'b0, 12'd0, 16'h0);
      @(negedge clk);
      checkOutput("ifs_if_gnt", if_gnt, 1);
      checkOutput("ifs_mem_en", mem_en, 1);
      checkOutput("ifs_mem_addr", mem_addr, i);
      checkOutput("ifs_mem_we", mem_we, 0);
      checkOutput("ifs_if_rvalid", if_rvalid, (i > 0) ? 1 : 0);
      if (i > 0) checkOutput("ifs_if_rdata", if_rdata, 32'hA000 + i - 1);
    end
    nextCycle();
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 16'h0);
    @(negedge clk);
    checkOutput("ifs_idle_mem_en", mem_en, 0);
    checkOutput("ifs_last_rvalid", if_rvalid, 1);
    checkOutput("ifs_last_rdata", if_rdata, 16'hA003);

    // Store then load of the same address
    nextCycle();
    applyStimulus(1'b0, 12'd0, 1'b1, 1'b1, 12'd100, 16'h1234);
    @(negedge clk);
    checkOutput("st_ls_gnt", ls_gnt, 1);
    checkOutput("st_mem_we", mem_we, 1);
    checkOutput("st_mem_addr", mem_addr, 100);
    checkOutput("st_mem_wdata", mem_wdata, 16'h1234);
    nextCycle();
    applyStimulus(1'b0, 12'd0, 1'b1, 1'b0, 12'd100, 16'h0);
    @(negedge clk);
    checkOutput("ld_ls_gnt", ls_gnt, 1);
    checkOutput("ld_mem_we", mem_we, 0);
    checkOutput("st_no_rvalid", ls_rvalid, 0);
    nextCycle();
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 16'h0);
    @(negedge clk);
    checkOutput("ld_ls_rvalid", ls_rvalid, 1);
    checkOutput("ld_ls_rdata", ls_rdata, 16'h1234);
    checkOutput("ld_if_rvalid", if_rvalid, 0);

    // Contention: LS x4 then IF, twice
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      applyStimulus(1'b1, 12'd5, 1'b1, 1'b0, 12'd7, 16'h0);
      @(negedge clk);
      checkOutput("con_if_gnt", if_gnt, contIf[i]);
      checkOutput("con_ls_gnt", ls_gnt, 1 - contIf[i]);
      if (i > 0) begin
        if (contIf[i-1] == 1) begin
          checkOutput("con_if_rvalid", if_rvalid, 1);
          checkOutput("con_if_rdata", if_rdata, 16'h5555);
        end else begin
          checkOutput("con_ls_rvalid", ls_rvalid, 1);
          checkOutput("con_ls_rdata", ls_rdata, 16'h7777);
        end
      end
    end

    // Streak clear: a cycle without if_req restarts the count
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      applyStimulus(clrIfReq[i] == 1, 12'd5, 1'b1, 1'b0, 12'd7, 16'h0);
      @(negedge clk);
      checkOutput("clr_if_gnt", if_gnt, clrExpIf[i]);
      checkOutput("clr_ls_gnt", ls_gnt, 1 - clrExpIf[i]);
    end

    // Reset right after a load grant drops the returning data
    nextCycle();
    applyStimulus(1'b0, 12'd0, 1'b1, 1'b0, 12'd7, 16'h0);
    @(negedge clk);
    checkOutput("rmr_ls_gnt", ls_gnt, 1);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 12'd2, 1'b1, 1'b0, 12'd7, 16'h0);
    @(negedge clk);
    checkOutput("rmr_ls_rvalid", ls_rvalid, 0);
    checkOutput("rmr_if_gnt", if_gnt, 0);
    checkOutput("rmr_ls_gnt", ls_gnt, 0);
    checkOutput("rmr_mem_en", mem_en, 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 16'h0);
    @(negedge clk);
    checkOutput("rmr_after_ls_rvalid", ls_rvalid, 0);
    checkOutput("rmr_after_if_rvalid", if_rvalid, 0);
    nextCycle();
    applyStimulus(1'b1, 12'd2, 1'b0, 1'b0, 12'd0, 16'h0);
    @(negedge clk);
    checkOutput("rmr_resume_if_gnt", if_gnt, 1);
    nextCycle();
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 16'h0);
    @(negedge clk);
    checkOutput("rmr_resume_rvalid", if_rvalid, 1);
    checkOutput("rmr_resume_rdata", if_rdata, 16'hA002);

`ifdef MEM_PORT_ARBITER_STATS_EN
    // Stall counters: clear, then LS,LS,LS,LS,IF,LS under contention
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      applyStimulus(1'b1, 12'd5, 1'b1, 1'b0, 12'd7, 16'h0);
    end
    nextCycle();
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 16'h0);
    @(negedge clk);
    checkOutput("stat_if_stall_cnt", if_stall_cnt, 5);
    checkOutput("stat_ls_stall_cnt", ls_stall_cnt, 1);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("stat_if_stall_clr", if_stall_cnt, 0);
    checkOutput("stat_ls_stall_clr", ls_stall_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between two requesters: instruction fetch (IF) and load/store (LS).
- Grants at most one memory access per cycle and drives the memory enable, write, address and write-data lines.
- Steers the one-cycle-latency read data back to whichever requester issued the read.
- LS has priority over IF. A streak limiter guarantees fetch progress during long load/store bursts.

Parameters:
- DWIDTH, 16, memory data width
- AWIDTH, 12, memory address width
- MAX_LS_STREAK, 4, maximum consecutive LS grants while IF is waiting (legal range 1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held until granted
- if_addr  in  AWIDTH  fetch address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (one cycle after if_gnt)
- if_rdata  out  DWIDTH  fetch data
- ls_req  in  1  load/store request; held until granted
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AWIDTH  load/store address
- ls_wdata  in  DWIDTH  store data
- ls_gnt  out  1  load/store accepted this cycle (combinational)
- ls_rvalid  out  1  load data valid (one cycle after a load grant; never asserted for stores)
- ls_rdata  out  DWIDTH  load data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AWIDTH  memory address
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory read data; valid the cycle after a read access

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset state: owner_q = NONE, streak_q = 0, if_rvalid = 0, ls_rvalid = 0.
- During reset: if_gnt, ls_gnt, mem_en and mem_we are forced to 0.
- Reset mid-operation: any read already in flight is dropped and its rvalid never asserts.
- Arbitration is combinational each cycle:
  - LS wins if ls_req=1, unless if_req=1 and streak_q == MAX_LS_STREAK; in that case IF wins.
  - Otherwise IF wins if if_req=1.
  - With no request, mem_en=0 and both grants are 0.
- The winner's grant is asserted and mem_en=1.
  - mem_addr is taken from the winner.
  - mem_we = ls_we when LS wins, else 0.
  - mem_wdata = ls_wdata when LS wins, else 0.
- Read-return owner register owner_q, states NONE / IF / LS, updated every cycle:
  - IF granted -> IF.
  - LS granted with ls_we=0 -> LS.
  - Otherwise (store granted, or no grant) -> NONE.
- Read return, in the cycle after the grant:
  - if_rvalid = (owner_q == IF); ls_rvalid = (owner_q == LS).
  - Both rdata outputs pass mem_rdata through combinationally.
  - rdata is don't-care when the matching rvalid is 0; the bench must not check it then.
- Throughput: back-to-back grants are allowed every cycle. A read granted at cycle N returns at N+1, concurrently with the grant at N+1.
- streak_q (4 bits), updated on the clock edge:
  - LS granted while if_req=1 -> streak_q+1.
  - IF granted, or if_req=0 -> 0.
  - It never exceeds MAX_LS_STREAK.
- Simultaneous requests with streak_q < MAX_LS_STREAK: LS granted, IF stalls with if_gnt=0 and must hold if_addr.
- A store followed by a load to the same address in consecutive cycles returns the stored value. This relies on the memory updating on the write edge.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- Defined: adds outputs if_stall_cnt (16 bits) and ls_stall_cnt (16 bits).
  - Each counts cycles where its req=1 and gnt=0.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - owner enum (OWNER_NONE=2'd0, OWNER_IF=2'd1, OWNER_LS=2'd2)
  - default widths: DWIDTH=16, AWIDTH=12
- Optional sub-module sat_counter (parameterised width, saturating increment, synchronous clear), instantiated twice under MEM_PORT_ARBITER_STATS_EN.
- Arbitration and owner tracking stay in the top module.

Test Plan:
- IF-only stream: if_req=1 with addresses 0,1,2,3 and memory preloaded 16'hA000+addr -> if_gnt every cycle; if_rvalid one cycle later with rdata A000, A001, A002, A003.
- Store then load: ls_we=1, addr 100, wdata 16'h1234, then load addr 100 -> mem_we=1 on the first cycle, no ls_rvalid for the store; ls_rvalid with ls_rdata 16'h1234 one cycle after the load grant.
- Contention with MAX_LS_STREAK=4: if_req and ls_req held high for 10 cycles -> grant pattern LS, LS, LS, LS, IF, LS, LS, LS, LS, IF.
- Streak clear: streak reaches 2, then if_req drops for one cycle, then IF and LS both request -> LS wins the next 4 contended grants before IF.
- Reset mid-read: load granted, rst=1 on the next cycle -> ls_rvalid=0, all grants 0, owner NONE; normal operation after rst falls.
- STATS_EN build: IF stalled for 5 cycles by LS -> if_stall_cnt=5; rst -> 0.
